// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the multiplier sharing front-end: op encodings,
// controller state encoding and default tag width.
package mul_share_ctrl_pkg;

    localparam int MUL_TAG_W = 4;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
    localparam logic [2:0] MUL_OP_MULW   = 3'b100;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_BUSY = 2'd1,
        CTRL_RESP = 2'd2
    } ctrl_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-request round-robin arbiter; the pointer moves to the losing
// requester only when a grant is actually accepted.
module mul_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // grant[0] accepted -> requester 1 is favoured next, and vice versa
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Arbitration/sequencing front-end for the shared iterative 64x64 multiplier.
// Optional watchdog abort is enabled by defining MUL_TIMEOUT_EN.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int TAG_W       = MUL_TAG_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_op_i,
    input  logic [63:0]       req0_rs1_i,
    input  logic [63:0]       req0_rs2_i,
    input  logic [TAG_W-1:0]  req0_tag_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_op_i,
    input  logic [63:0]       req1_rs1_i,
    input  logic [63:0]       req1_rs2_i,
    input  logic [TAG_W-1:0]  req1_tag_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_id_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic [63:0]       resp_data_o,
    output logic              resp_err_o,
    input  logic              flush_i,
    output logic              mul_valid_o,
    input  logic              mul_ready_i,
    output logic [63:0]       mul_rs1_o,
    output logic [63:0]       mul_rs2_o,
    output logic              mul_rs1_signed_o,
    output logic              mul_rs2_signed_o,
    input  logic [127:0]      mul_out_i,
    output logic              busy_o
);

    ctrl_state_t      state;
    logic [1:0]       req_vld;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_id;
    logic             timeout_hit;

    logic [2:0]       op_sel;
    logic [63:0]      rs1_sel;
    logic [63:0]      rs2_sel;
    logic [TAG_W-1:0] tag_sel;
    logic [2:0]       op_norm;
    logic [63:0]      rs1_n;
    logic [63:0]      rs2_n;
    logic             s1_n;
    logic             s2_n;

    logic [2:0]       op_q;
    logic             id_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      rs1_q;
    logic [63:0]      rs2_q;
    logic             s1_q;
    logic             s2_q;
    logic [63:0]      data_q;
    logic             err_q;
    logic [63:0]      res_sel;

    assign req_vld = {req1_valid_i, req0_valid_i};

    mul_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vld),
        .accept (accept),
        .grant  (grant)
    );

    assign req0_ready_o = (state == CTRL_IDLE) & ~flush_i & grant[0];
    assign req1_ready_o = (state == CTRL_IDLE) & ~flush_i & grant[1];
    assign accept       = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
    assign acc_id       = grant[1];

    // Operand selection and sign preparation for the winning request
    always_comb begin
        op_sel  = acc_id ? req1_op_i  : req0_op_i;
        rs1_sel = acc_id ? req1_rs1_i : req0_rs1_i;
        rs2_sel = acc_id ? req1_rs2_i : req0_rs2_i;
        tag_sel = acc_id ? req1_tag_i : req0_tag_i;
        op_norm = (op_sel > MUL_OP_MULW) ? MUL_OP_MUL : op_sel;
        rs1_n   = rs1_sel;
        rs2_n   = rs2_sel;
        s1_n    = 1'b1;
        s2_n    = 1'b1;
        case (op_norm)
            MUL_OP_MULHSU: s2_n = 1'b0;
            MUL_OP_MULHU: begin
                s1_n = 1'b0;
                s2_n = 1'b0;
            end
            MUL_OP_MULW: begin
                rs1_n = sext32(rs1_sel[31:0]);
                rs2_n = sext32(rs2_sel[31:0]);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: res_sel = mul_out_i[127:64];
            MUL_OP_MULW:                            res_sel = sext32(mul_out_i[31:0]);
            default:                                res_sel = mul_out_i[63:0];
        endcase
    end

`ifdef MUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign timeout_hit = (state == CTRL_BUSY) && (cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != CTRL_BUSY) begin
            cnt <= '0;
        end else if (!timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    // Multiplier aborts on a valid drop, so valid stays up for all of BUSY
    // except the ready-pulse, flush and watchdog cycles.
    assign mul_valid_o = (state == CTRL_BUSY) & ~mul_ready_i & ~flush_i & ~timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CTRL_IDLE;
            op_q   <= MUL_OP_MUL;
            id_q   <= 1'b0;
            tag_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                CTRL_IDLE: begin
                    if (accept) begin
                        op_q  <= op_norm;
                        id_q  <= acc_id;
                        tag_q <= tag_sel;
                        rs1_q <= rs1_n;
                        rs2_q <= rs2_n;
                        s1_q  <= s1_n;
                        s2_q  <= s2_n;
                        err_q <= 1'b0;
                        state <= CTRL_BUSY;
                    end
                end
                CTRL_BUSY: begin
                    if (flush_i) begin
                        state <= CTRL_IDLE;
                    end else if (mul_ready_i) begin
                        data_q <= res_sel;
                        err_q  <= 1'b0;
                        state  <= CTRL_RESP;
                    end else if (timeout_hit) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                        state  <= CTRL_RESP;
                    end
                end
                CTRL_RESP: begin
                    if (flush_i || resp_ready_i) begin
                        err_q <= 1'b0;
                        state <= CTRL_IDLE;
                    end
                end
                default: state <= CTRL_IDLE;
            endcase
        end
    end

    assign resp_valid_o     = (state == CTRL_RESP);
    assign resp_id_o        = id_q;
    assign resp_tag_o       = tag_q;
    assign resp_data_o      = data_q;
    assign resp_err_o       = err_q;
    assign mul_rs1_o        = rs1_q;
    assign mul_rs2_o        = rs2_q;
    assign mul_rs1_signed_o = s1_q;
    assign mul_rs2_signed_o = s2_q;
    assign busy_o           = (state != CTRL_IDLE);

endmodule
